serial_seq_generator: RTL
=========================

# serial_seq_generator

Serial bit-sequence transmitter: accepts a parallel pattern of up to WIDTH bits and shifts it out MSB-first, one bit per clock, optionally repeated a programmed number of times. It is the transmit-side counterpart of the team's serial sequence detector and drives its `in` line, for example with pattern 0110, in loopback benches and on the board. All outputs are registered.

## Interface
- WIDTH, 8: maximum pattern length in bits.
- LEN_W, 4: width of `len`; must satisfy 2^LEN_W > WIDTH.
- CNT_W, 4: width of `repeat`.
- GAP, 2: idle bit-times inserted between repetitions. Used only when SSG_GAP_EN is defined; must be ≥1.
- IDLE_LVL, 1'b1: level of `out` whenever no pattern bit is being sent.
- clock, input, 1: rising-edge clock, the only clock.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a transmission; sampled only while `busy`=0.
- pattern, input, WIDTH: bits to send; bit len-1 goes out first, bit 0 last.
- len, input, LEN_W: number of pattern bits. 0 means send nothing. Values above WIDTH are clamped to WIDTH.
- repeat, input, CNT_W: extra repetitions; total sends = repeat+1.
- out, output, 1: serial data.
- valid, output, 1: high in every cycle where `out` carries a pattern bit.
- busy, output, 1: high from the first bit through the last bit, including gaps.
- done, output, 1: one-cycle pulse after a transmission completes.

## Operation
- FSM states:
  - IDLE: `out`=IDLE_LVL, `valid`=0, `busy`=0, `done`=0.
  - SEND: one bit per cycle from the captured shift register. A bit counter counts down from len-1 to 0.
  - GAP: `out`=IDLE_LVL, `valid`=0, `busy`=1. Lasts GAP cycles.
  - DONE: `done`=1, `busy`=0. Lasts one cycle.
- Accepting a request: `start`=1 with `busy`=0 in IDLE or DONE captures `pattern`, clamped `len` and `repeat` into internal registers. `start` is ignored while `busy`=1. Inputs may change freely after capture.
- Transitions:
  - IDLE/DONE + accepted start with len≠0 → SEND.
  - IDLE/DONE + accepted start with len=0 → DONE. Nothing is sent and `valid` never rises.
  - DONE with no start → IDLE.
  - SEND, last bit, repetitions remaining → GAP (SSG_GAP_EN defined) or SEND restarting at bit len-1 (not defined). The repetition counter decrements.
  - SEND, last bit, no repetitions remaining → DONE.
  - GAP, final gap cycle → SEND at bit len-1.
- The shift register reloads from the captured pattern on each repetition, so all repetitions send identical bits.
- Counter widths: the bit counter is LEN_W wide and the repetition counter is CNT_W wide. repeat = 2^CNT_W−1 gives 2^CNT_W sends; no wrap to 0 is permitted.
- Reset: state=IDLE, `out`=IDLE_LVL, `valid`=0, `busy`=0, `done`=0, internal registers cleared. Reset mid-transmission aborts at the next edge with no `done` pulse.

## Timing
- `start` sampled high at edge T0 → first bit (pattern[len-1]) on `out` with `valid`=`busy`=1 during the cycle after T0, i.e. 1-cycle latency.
- Each bit is held exactly one cycle; there are no bubbles within a repetition.
- `busy` stays high for (repeat+1)·len cycles, plus repeat·GAP cycles when SSG_GAP_EN is defined.
- `done` is high in the cycle immediately after the final bit, with `out`=IDLE_LVL and `valid`=0.
- A `start` sampled in the DONE cycle is accepted; its first bit appears in the next cycle, giving back-to-back jobs with one idle cycle between them.
- When `start` and `reset` are high on the same edge, reset wins.

## Configuration
- SSG_GAP_EN defined: GAP state present; GAP idle-level bit-times separate repetitions.
- SSG_GAP_EN undefined: GAP state, its counter and the GAP parameter's logic are not compiled. Repetitions are sent back-to-back.
- In both builds the first repetition and the trailing `done` timing are unchanged.

## Test plan
- Reset, then pattern=8'b0000_0110, len=4, repeat=0, start for one cycle → `out` = 0,1,1,0 on cycles T0+1..T0+4 with `valid`=`busy`=1; `done`=1 at T0+5; `out`=1 otherwise. Loopback into the detector drives its `g` high.
- len=3, pattern=3'b101, repeat=2 → gap build: 101,1,1,101,1,1,101 with `valid` low in the gaps and `busy` high for 13 cycles. No-gap build: 101101101 with `busy` high for 9 cycles.
- len=0, start → `done` pulses at T0+1; `valid` and `busy` never rise.
- len=15 with WIDTH=8 → exactly 8 bits sent (clamp). `start` pulsed during `busy` → ignored, bit stream unaffected.
- Assert `reset` on the 3rd bit of a 4-bit send → next cycle `out`=IDLE_LVL, `busy`=0, no `done`. A start two cycles later transmits normally.
- Hold `start` high continuously with len=2, pattern=2'b10 → sequence 1,0,idle(`done`),1,0,idle(`done`)… repeating with period 3.

Source files
------------

// File: rtl/serial_seq_generator.sv
// serial_seq_generator
// Shifts a captured parallel pattern out MSB-first (bit len-1 first), one bit
// per clock, repeated repeat+1 times. Outputs are registered.
//
// Optional feature macro: SSG_GAP_EN
//   defined   : GAP idle-level bit-times are inserted between repetitions
//   undefined : repetitions are sent back-to-back (GAP state not built)
//
// Ports
//   clock_i    rising-edge clock
//   reset_i    synchronous active-high reset
//   start_i    transmission request, sampled only while busy_o = 0
//   pattern_i  bits to send, bit len-1 first, bit 0 last
//   len_i      pattern length, 0 = send nothing, clamped to WIDTH
//   repeat_i   extra repetitions (total sends = repeat_i + 1)
//   out_o      serial data, IDLE_LVL when no pattern bit is sent
//   valid_o    out_o carries a pattern bit
//   busy_o     high from first bit through last bit, gaps included
//   done_o     one-cycle pulse after the final bit
//
// state  | meaning
// S_IDLE | waiting for start, out = IDLE_LVL
// S_SEND | one pattern bit per cycle from the shift register
// S_GAP  | idle-level bit-times between repetitions (SSG_GAP_EN only)
// S_DONE | one-cycle completion pulse, start accepted here too

module serial_seq_generator #(
    parameter int   WIDTH    = 8,
    parameter int   LEN_W    = 4,
    parameter int   CNT_W    = 4,
    parameter int   GAP      = 2,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] pattern_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [CNT_W-1:0] repeat_i,
    output logic             out_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             done_o
);

    if (GAP < 1 || (1 << LEN_W) <= WIDTH) begin : g_bad_cfg
        $error("serial_seq_generator: GAP must be >= 1 and 2**LEN_W > WIDTH");
    end

    localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_DONE = 2'd2
`ifdef SSG_GAP_EN
        ,
        S_GAP  = 2'd3
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;   // captured pattern, left-aligned
    logic [WIDTH-1:0] sh_q, sh_d;     // working shift register, MSB is on the line
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] bit_q, bit_d;   // index of the bit currently on out_o
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef SSG_GAP_EN
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    logic [LEN_W-1:0] len_clamp;
    logic [WIDTH-1:0] pat_align;
    logic [WIDTH-1:0] sh_shift;

    // Left-align so pattern bit len-1 sits in the MSB; every send then
    // simply shifts left and always drives the MSB.
    always_comb begin
        len_clamp = (len_i > WIDTH_L) ? WIDTH_L : len_i;
        pat_align = pattern_i << (WIDTH_L - len_clamp);
        sh_shift  = sh_q << 1;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sh_q    <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            rep_q   <= '0;
            out_q   <= IDLE_LVL;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SSG_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sh_q    <= sh_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SSG_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sh_d    = sh_q;
        len_d   = len_q;
        bit_d   = bit_q;
        rep_d   = rep_q;
        out_d   = IDLE_LVL;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SSG_GAP_EN
        gap_d   = gap_q;
`endif

        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    pat_d = pat_align;
                    len_d = len_clamp;
                    rep_d = repeat_i;
                    if (len_clamp != '0) begin
                        state_d = S_SEND;
                        sh_d    = pat_align;
                        bit_d   = len_clamp - LEN_W'(1);
                        out_d   = pat_align[WIDTH-1];
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_SEND: begin
                if (bit_q != '0) begin
                    sh_d    = sh_shift;
                    bit_d   = bit_q - LEN_W'(1);
                    out_d   = sh_shift[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d = rep_q - CNT_W'(1);
`ifdef SSG_GAP_EN
                    state_d = S_GAP;
                    gap_d   = GAP_W'(GAP - 1);
                    busy_d  = 1'b1;
`else
                    sh_d    = pat_q;
                    bit_d   = len_q - LEN_W'(1);
                    out_d   = pat_q[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
`endif
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end

`ifdef SSG_GAP_EN
            S_GAP: begin
                busy_d = 1'b1;
                if (gap_q == '0) begin
                    state_d = S_SEND;
                    sh_d    = pat_q;
                    bit_d   = len_q - LEN_W'(1);
                    out_d   = pat_q[WIDTH-1];
                    valid_d = 1'b1;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    assign out_o   = out_q;
    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule
